au_pipe: RTL and testbench

AU_PIPE -- requirements
Module: au_pipe

---
 rtl/au_pipe.sv | 137 +++++++++++++
 tb/tb_au_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_pipe.sv
// au_pipe: two-stage valid/ready arithmetic pipeline with saturating or
// wrapping W-bit results and an internal accumulator.
module au_pipe #(
    parameter int W   = 16,
    parameter bit SAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   op,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);
    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MAX = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b011;
    localparam logic [2:0] OP_ACC = 3'b100;
    localparam logic [2:0] OP_ABS = 3'b101;

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;
    logic [2:0]   s1_op_q, s1_op_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_data_q, s2_data_d;
    logic         s2_ovf_q, s2_ovf_d;
    logic [W-1:0] acc_q, acc_d;

    logic         s2_adv, s1_adv, in_fire;
    logic [W-1:0] acc_base;
    logic [W:0]   ext_a, ext_b, ext_acc, diff, wide;
    logic         use_wide, res_ovf;
    logic [W-1:0] res;

    always_comb begin
        s2_adv  = !s2_valid_q || out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_ready = s1_adv && !rst;
        in_fire = in_valid && in_ready;

        // acc_clr on the same edge as an ACC advance makes the add start from 0
        acc_base = acc_clr ? '0 : acc_q;
        ext_a    = {s1_a_q[W-1], s1_a_q};
        ext_b    = {s1_b_q[W-1], s1_b_q};
        ext_acc  = {acc_base[W-1], acc_base};
        diff     = ext_a - ext_b;

        wide     = diff;
        use_wide = 1'b1;
        res      = s1_a_q;
        unique case (s1_op_q)
            OP_SUB: wide = diff;
            OP_ADD: wide = ext_a + ext_b;
            OP_MAX: begin
                use_wide = 1'b0;
                res      = diff[W] ? s1_b_q : s1_a_q;
            end
            OP_MIN: begin
                use_wide = 1'b0;
                res      = (!diff[W] && diff != '0) ? s1_b_q : s1_a_q;
            end
            OP_ACC: wide = ext_acc + ext_a;
            OP_ABS: wide = diff[W] ? -diff : diff;
            default: begin
                use_wide = 1'b0;
                res      = s1_a_q;
            end
        endcase

        res_ovf = use_wide && (wide[W] != wide[W-1]);
        if (use_wide) begin
            if (res_ovf && SAT) res = wide[W] ? MIN_V : MAX_V;
            else                res = wide[W-1:0];
        end

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv) s1_valid_d = in_fire;
        if (in_fire) begin
            s1_a_d  = in_a;
            s1_b_d  = in_b;
            s1_op_d = op;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res;
                s2_ovf_d  = res_ovf;
            end
        end

        acc_d = acc_base;
        if (s2_adv && s1_valid_q && s1_op_q == OP_ACC) acc_d = res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid = s2_valid_q && !rst;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;
endmodule

// File: tb/tb_au_pipe.sv
// tb_au_pipe: scoreboard bench for au_pipe, one saturating and one wrapping
// instance driven by the same stimulus.
module tb_au_pipe;
    localparam int W    = 16;
    localparam int MAXI = 2 ** (W - 1) - 1;
    localparam int MINI = -(2 ** (W - 1));

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, acc_clr;
    logic [2:0]   op;
    logic [W-1:0] in_a, in_b;
    logic         in_ready0, in_ready1, ov0, ov1, of0, of1;
    logic [W-1:0] od0, od1;

    always #5 clk = ~clk;

    au_pipe #(.W(W), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .op(op), .acc_clr(acc_clr),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ovf(of0)
    );
    au_pipe #(.W(W), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .op(op), .acc_clr(acc_clr),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(of1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int pushed = 0;
    int popped = 0;
    int dropped = 0;
    logic [W:0] q0[$];
    logic [W:0] q1[$];
    int macc[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer result, then range check and clamp/wrap.
    function automatic logic [W:0] ref_op(input bit sat, input logic [2:0] o,
                                          input int a, input int b,
                                          input int acc);
        int r;
        r = 0;
        case (o)
            3'd0: r = a - b;
            3'd1: r = a + b;
            3'd2: return {1'b0, W'(a >= b ? a : b)};
            3'd3: return {1'b0, W'(a <= b ? a : b)};
            3'd4: r = acc + a;
            3'd5: r = a > b ? a - b : b - a;
            default: return {1'b0, W'(a)};
        endcase
        if (r > MAXI || r < MINI) begin
            if (sat) return {1'b1, W'(r > 0 ? MAXI : MINI)};
            return {1'b1, W'(r)};
        end
        return {1'b0, W'(r)};
    endfunction

    always @(negedge clk) begin : in_mon
        logic [W:0] e0, e1;
        int a, b;
        if (rst) begin
            dropped += q0.size();
            q0.delete();
            q1.delete();
            macc[0] = 0;
            macc[1] = 0;
        end else if (in_valid && in_ready0) begin
            a = int'($signed(in_a));
            b = int'($signed(in_b));
            if (acc_clr && op == 3'd4) begin
                macc[0] = 0;
                macc[1] = 0;
            end
            e0 = ref_op(1'b1, op, a, b, macc[0]);
            e1 = ref_op(1'b0, op, a, b, macc[1]);
            if (op == 3'd4) begin
                macc[0] = int'($signed(e0[W-1:0]));
                macc[1] = int'($signed(e1[W-1:0]));
            end
            q0.push_back(e0);
            q1.push_back(e1);
            pushed++;
        end
    end

    logic         hold_v = 1'b0;
    logic [W:0]   hold_x;

    always @(negedge clk) begin : out_mon
        logic [W:0] e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(ov0), 32'd1);
                chk("stall_data", 32'({of0, od0}), 32'(hold_x));
            end
            if (ov0 || ov1) chk("valid_pair", 32'(ov1), 32'(ov0));
            if (ov0 && out_ready) begin
                if (q0.size() == 0) chk("sat_underflow", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("sat_result", 32'({of0, od0}), 32'(e));
                end
                if (q1.size() == 0) chk("wrap_underflow", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("wrap_result", 32'({of1, od1}), 32'(e));
                end
                popped++;
            end
            hold_v = ov0 && !out_ready;
            hold_x = {of0, od0};
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        in_valid = 1'b1;
        op = o;
        in_a = a;
        in_b = b;
        acc_clr = c;
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_ready0;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        if (c) begin
            @(posedge clk);
            #1;
            acc_clr = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(7))
            0: return {1'b0, {(W-1){1'b1}}};
            1: return {1'b1, {(W-1){1'b0}}};
            2: return W'($urandom_range(3));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin : stim
        int idx, gaps, sent, guard;
        logic fire;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        acc_clr = 1'b0;
        op = '0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        chk("rst_out_data", 32'(od0), 32'd0);
        chk("rst_out_ovf", 32'(of0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;

        send(3'd1, 16'h7000, 16'h2000, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", 32'(ov0), 32'd0);
        @(negedge clk);
        chk("lat_cycle2", 32'(ov0), 32'd1);
        chk("add_sat", 32'({of0, od0}), 32'h17fff);
        chk("add_wrap", 32'({of1, od1}), 32'h19000);
        drain();

        send(3'd2, 16'h8000, 16'h0001, 1'b0);
        send(3'd3, 16'h7fff, 16'h8000, 1'b0);
        send(3'd5, 16'h7fff, 16'h8000, 1'b0);
        send(3'd6, 16'h1234, 16'h5678, 1'b0);
        send(3'd0, 16'h8000, 16'h0001, 1'b0);
        drain();

        send(3'd4, 16'd100, 16'd0, 1'b0);
        send(3'd4, 16'd200, 16'd0, 1'b0);
        send(3'd4, 16'hffce, 16'd0, 1'b0);
        drain();
        send(3'd4, 16'd7, 16'd0, 1'b1);
        drain();

        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        op = 3'd1;
        repeat (6) begin
            in_a = W'(idx * 1000);
            in_b = W'(idx);
            @(negedge clk);
            fire = in_ready0;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        chk("stall_accepts", 32'(idx), 32'd2);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready0), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        gaps = 0;
        repeat (5) begin
            in_a = W'(idx * 1000);
            in_b = W'(idx);
            @(negedge clk);
            gaps += int'(ov0);
            fire = in_valid && in_ready0;
            @(posedge clk);
            #1;
            if (fire) idx++;
            in_valid = idx < 5;
        end
        chk("release_no_gaps", 32'(gaps), 32'd5);
        chk("release_all_sent", 32'(idx), 32'd5);
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        op = 3'd4;
        in_a = 16'd9;
        repeat (4) begin
            @(negedge clk);
            fire = in_ready0;
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        chk("fill_both", 32'(idx), 32'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(in_ready0), 32'd1);
        chk("rst_mid_valid", 32'(ov0), 32'd0);
        @(negedge clk);
        chk("rst_mid_valid2", 32'(ov0), 32'd0);
        @(posedge clk);
        #1;
        send(3'd4, 16'd5, 16'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("acc_after_rst", 32'({ov0, od0}), 32'h10005);
        drain();

        sent = 0;
        guard = 0;
        fire = 1'b0;
        in_valid = 1'b0;
        while (sent < 10000 && guard < 60000) begin
            if (!in_valid || fire) begin
                in_valid = $urandom_range(3) != 0;
                op = 3'($urandom_range(7));
                in_a = rnd();
                in_b = rnd();
            end
            out_ready = $urandom_range(3) != 0;
            @(negedge clk);
            fire = in_valid && in_ready0;
            if (fire) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("random_sent", 32'(sent), 32'd10000);
        chk("no_drop_dup", 32'(popped + dropped), 32'(pushed));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
